// File: rtl/ahb_pkg.sv
// Shared AHB types and widths for the round-robin bus arbiter.
package ahb_pkg;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int TRANS_W = 2;
   localparam int RESP_W  = 2;

   typedef enum logic [1:0] {
      HT_IDLE   = 2'b00,
      HT_BUSY   = 2'b01,
      HT_SEQ    = 2'b10,
      HT_NONSEQ = 2'b11
   } htrans_t;

   typedef enum logic {
      PARK = 1'b0,
      OWN  = 1'b1
   } arb_state_t;

   // A transfer that the slave counts as a real beat.
   function automatic logic is_active(input htrans_t t);
      return (t == HT_NONSEQ) || (t == HT_SEQ);
   endfunction

   // Mid-burst: the grant must not move while this holds.
   function automatic logic in_burst(input htrans_t t);
      return (t == HT_SEQ) || (t == HT_BUSY);
   endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// Bundle of master-side and slave-side AHB signals around the arbiter.
// The slave modport is the arbiter's view; the master modport is the
// environment (masters plus the shared slave) that drives it.
interface ahb_arbiter_if #(
   parameter int NUM_MASTERS = 2
);
   import ahb_pkg::*;

   localparam int MW = $clog2(NUM_MASTERS);

   logic [NUM_MASTERS-1:0]         hbusreq;
   logic [NUM_MASTERS*ADDR_W-1:0]  m_haddr;
   logic [NUM_MASTERS*DATA_W-1:0]  m_hwdata;
   logic [NUM_MASTERS-1:0]         m_hwrite;
   logic [NUM_MASTERS*TRANS_W-1:0] m_htrans;
   logic [NUM_MASTERS-1:0]         m_hreadyin;
   logic                           hreadyout;
   logic [DATA_W-1:0]              hrdata;
   logic [RESP_W-1:0]              hresp;

   logic [NUM_MASTERS-1:0]         hgrant;
   logic [MW-1:0]                  hmaster;
   logic [ADDR_W-1:0]              s_haddr;
   logic [DATA_W-1:0]              s_hwdata;
   logic                           s_hwrite;
   logic                           s_hreadyin;
   logic [TRANS_W-1:0]             s_htrans;
   logic [NUM_MASTERS-1:0]         m_hreadyout;
   logic [NUM_MASTERS*DATA_W-1:0]  m_hrdata;
   logic [NUM_MASTERS*RESP_W-1:0]  m_hresp;

   modport slave (
      input  hbusreq, m_haddr, m_hwdata, m_hwrite, m_htrans, m_hreadyin,
             hreadyout, hrdata, hresp,
      output hgrant, hmaster, s_haddr, s_hwdata, s_hwrite, s_hreadyin,
             s_htrans, m_hreadyout, m_hrdata, m_hresp
   );

   modport master (
      output hbusreq, m_haddr, m_hwdata, m_hwrite, m_htrans, m_hreadyin,
             hreadyout, hrdata, hresp,
      input  hgrant, hmaster, s_haddr, s_hwdata, s_hwrite, s_hreadyin,
             s_htrans, m_hreadyout, m_hrdata, m_hresp
   );

endinterface

// File: rtl/ahb_arbiter_rr_select.sv
// Combinational round-robin picker: the first requester after ptr wins.
module rr_select #(
   parameter int NUM_MASTERS = 2,
   parameter int PTR_W       = $clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [PTR_W-1:0]       ptr,
   output logic [NUM_MASTERS-1:0] gnt,
   output logic                   vld
);

   logic [PTR_W:0]           shift;
   logic [PTR_W:0]           back;
   logic [NUM_MASTERS-1:0]   rot_req;
   logic [NUM_MASTERS-1:0]   rot_gnt;

   // Rotate so ptr+1 sits at bit 0, take the lowest set bit, rotate back.
   always_comb begin
      shift   = {1'b0, ptr} + (PTR_W+1)'(1);
      back    = (PTR_W+1)'(NUM_MASTERS) - shift;
      rot_req = NUM_MASTERS'({req, req} >> shift);
      rot_gnt = rot_req & (-rot_req);
      gnt     = NUM_MASTERS'({rot_gnt, rot_gnt} >> back);
      vld     = |req;
   end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin, burst-aware AHB arbiter sharing one slave among masters.
// Grant and owner are registered; address/control follow the owner while
// write data follows the previous owner, matching the AHB phase offset.
module ahb_arbiter
   import ahb_pkg::*;
#(
   parameter int NUM_MASTERS    = 2,
   parameter int DEFAULT_MASTER = 0,
   parameter int MAX_BEATS      = 16
) (
   input logic          hclk,
   input logic          hreset,
   ahb_arbiter_if.slave bus
);

   localparam int MW = $clog2(NUM_MASTERS);
   localparam int CW = $clog2(MAX_BEATS + 1);
   localparam logic [NUM_MASTERS-1:0] DEF_GNT  = NUM_MASTERS'(1) << DEFAULT_MASTER;
   localparam logic [MW-1:0]          DEF_IDX  = MW'(DEFAULT_MASTER);
   localparam logic [CW-1:0]          BEAT_MAX = CW'(MAX_BEATS);

   arb_state_t             state;
   logic [NUM_MASTERS-1:0] grant;
   logic [MW-1:0]          owner;
   logic [MW-1:0]          data_owner;
   logic [MW-1:0]          last_owner;
   logic [CW-1:0]          beat_cnt;

   logic [NUM_MASTERS-1:0] sel_gnt;
   logic                   sel_vld;
   logic [MW-1:0]          sel_idx;

   htrans_t                owner_trans;
   htrans_t                bus_trans;
   logic                   owner_req;
   logic                   cap_hit;
   logic                   arb_point;
   arb_state_t             next_state;
   logic [NUM_MASTERS-1:0] next_grant;
   logic [MW-1:0]          next_owner;
   logic                   grant_change;
   logic                   beat_inc;

   function automatic logic [MW-1:0] onehot_idx(input logic [NUM_MASTERS-1:0] oh);
      logic [MW-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_MASTERS; i++)
         if (oh[i]) idx = MW'(i);
      return idx;
   endfunction

   rr_select #(
      .NUM_MASTERS (NUM_MASTERS),
      .PTR_W       (MW)
   ) u_rr_select (
      .req (bus.hbusreq),
      .ptr (last_owner),
      .gnt (sel_gnt),
      .vld (sel_vld)
   );

   // Decide whether this edge may move the grant and where it would go.
   always_comb begin
      owner_trans  = htrans_t'(bus.m_htrans[TRANS_W*owner +: TRANS_W]);
      owner_req    = bus.hbusreq[owner];
      bus_trans    = (state == PARK) ? HT_IDLE : owner_trans;
      cap_hit      = (beat_cnt >= BEAT_MAX) &&
                     ((owner_trans == HT_NONSEQ) || (owner_trans == HT_IDLE));
      arb_point    = bus.hreadyout &&
                     ((state == PARK) ||
                      (!in_burst(owner_trans) &&
                       ((owner_trans == HT_IDLE) || !owner_req || cap_hit)));
      sel_idx      = onehot_idx(sel_gnt);
      next_state   = sel_vld ? OWN : PARK;
      next_grant   = sel_vld ? sel_gnt : DEF_GNT;
      next_owner   = sel_vld ? sel_idx : DEF_IDX;
      grant_change = (next_grant != grant) || (next_state != state);
      beat_inc     = is_active(bus_trans);
   end

   // Arbitration FSM with registered grant, owners, pointer and beat count.
   always_ff @(posedge hclk) begin
      if (hreset) begin
         state      <= PARK;
         grant      <= DEF_GNT;
         owner      <= DEF_IDX;
         data_owner <= DEF_IDX;
         last_owner <= DEF_IDX;
         beat_cnt   <= '0;
      end else if (bus.hreadyout) begin
         data_owner <= owner;
         if (arb_point) begin
            state <= next_state;
            grant <= next_grant;
            owner <= next_owner;
            if (sel_vld) last_owner <= sel_idx;
         end
         if (arb_point && grant_change)
            beat_cnt <= '0;
         else if (beat_inc && (beat_cnt < BEAT_MAX))
            beat_cnt <= beat_cnt + CW'(1);
      end
   end

   assign bus.hgrant      = grant;
   assign bus.hmaster     = owner;
   assign bus.s_haddr     = bus.m_haddr[ADDR_W*owner +: ADDR_W];
   assign bus.s_hwrite    = bus.m_hwrite[owner];
   assign bus.s_hreadyin  = bus.m_hreadyin[owner];
   assign bus.s_htrans    = bus_trans;
   assign bus.s_hwdata    = bus.m_hwdata[DATA_W*data_owner +: DATA_W];
   assign bus.m_hreadyout = {NUM_MASTERS{bus.hreadyout}};
   assign bus.m_hrdata    = {NUM_MASTERS{bus.hrdata}};
   assign bus.m_hresp     = {NUM_MASTERS{bus.hresp}};

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: two masters, DEFAULT_MASTER=0, MAX_BEATS=4.
module tb_ahb_arbiter;

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] SEQ    = 2'b10;
   localparam logic [1:0] NONSEQ = 2'b11;

   logic hclk;
   logic hreset;
   int   checks   = 0;
   int   failures = 0;

   ahb_arbiter_if #(.NUM_MASTERS(2)) bus ();

   ahb_arbiter #(
      .NUM_MASTERS    (2),
      .DEFAULT_MASTER (0),
      .MAX_BEATS      (4)
   ) dut (
      .hclk   (hclk),
      .hreset (hreset),
      .bus    (bus.slave)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge hclk);
      #1;
   endtask

   task automatic drive(input int i, input logic req, input logic [1:0] tr,
                        input logic [31:0] addr);
      bus.hbusreq[i]           = req;
      bus.m_htrans[2*i +: 2]   = tr;
      bus.m_haddr[32*i +: 32]  = addr;
      bus.m_hwrite[i]          = 1'b1;
   endtask

   task automatic set_wd(input int i, input logic [31:0] wd);
      bus.m_hwdata[32*i +: 32] = wd;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      hreset         = 1'b1;
      bus.hbusreq    = '0;
      bus.m_haddr    = '0;
      bus.m_hwdata   = '0;
      bus.m_hwrite   = '0;
      bus.m_htrans   = '0;
      bus.m_hreadyin = '1;
      bus.hreadyout  = 1'b1;
      bus.hrdata     = 32'hDEAD_BEEF;
      bus.hresp      = 2'b01;
      cyc();
      cyc();

      // Reset state and response broadcast
      check("rst_hgrant", bus.hgrant, 64'h1);
      check("rst_hmaster", bus.hmaster, 64'h0);
      check("rst_htrans", bus.s_htrans, IDLE);
      check("bcast_hrdata", bus.m_hrdata, 64'hDEAD_BEEF_DEAD_BEEF);
      check("bcast_hresp", bus.m_hresp, 64'h5);
      check("bcast_hready", bus.m_hreadyout, 64'h3);

      // Parked with no requests
      hreset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         check("park_hgrant", bus.hgrant, 64'h1);
         check("park_hmaster", bus.hmaster, 64'h0);
         check("park_htrans", bus.s_htrans, IDLE);
      end

      // M1 alone, single write 0x2 / data 0x2
      drive(1, 1'b1, NONSEQ, 32'h2);
      cyc();
      check("t2_hgrant", bus.hgrant, 64'h2);
      check("t2_hmaster", bus.hmaster, 64'h1);
      check("t2_haddr", bus.s_haddr, 64'h2);
      check("t2_htrans", bus.s_htrans, NONSEQ);
      check("t2_hwrite", bus.s_hwrite, 64'h1);
      bus.hbusreq[1] = 1'b0;
      cyc();
      check("t2_park_hgrant", bus.hgrant, 64'h1);
      drive(1, 1'b0, IDLE, 32'h2);
      set_wd(1, 32'h2);
      #1;
      check("t2_hwdata", bus.s_hwdata, 64'h2);
      check("t2_park_htrans", bus.s_htrans, IDLE);

      // Simultaneous requests from reset: M1 first, then M0
      hreset = 1'b1;
      cyc();
      hreset = 1'b0;
      drive(0, 1'b1, NONSEQ, 32'h10);
      drive(1, 1'b1, NONSEQ, 32'h20);
      cyc();
      check("t3_first_hgrant", bus.hgrant, 64'h2);
      check("t3_first_haddr", bus.s_haddr, 64'h20);
      cyc();
      check("t3_hold_hgrant", bus.hgrant, 64'h2);
      drive(1, 1'b1, IDLE, 32'h20);
      cyc();
      check("t3_second_hgrant", bus.hgrant, 64'h1);
      check("t3_second_hmaster", bus.hmaster, 64'h0);
      check("t3_second_haddr", bus.s_haddr, 64'h10);
      check("t3_second_htrans", bus.s_htrans, NONSEQ);
      drive(0, 1'b0, IDLE, 32'h0);
      drive(1, 1'b0, IDLE, 32'h0);
      cyc();
      check("t3_park_hgrant", bus.hgrant, 64'h1);
      check("t3_park_htrans", bus.s_htrans, IDLE);

      // M0 8-beat burst, M1 requests at beat 3
      drive(0, 1'b1, NONSEQ, 32'h100);
      cyc();
      check("t4_hgrant", bus.hgrant, 64'h1);
      check("t4_htrans", bus.s_htrans, NONSEQ);
      check("t4_haddr", bus.s_haddr, 64'h100);
      for (int k = 1; k < 8; k++) begin
         cyc();
         check("t4_hold_hgrant", bus.hgrant, 64'h1);
         drive(0, 1'b1, SEQ, 32'h100 + 32'(k));
         set_wd(0, 32'h100 + 32'(k) - 32'h1);
         if (k == 3) drive(1, 1'b1, NONSEQ, 32'h200);
      end
      cyc();
      check("t4_hold_last", bus.hgrant, 64'h1);
      drive(0, 1'b0, IDLE, 32'h107);
      set_wd(0, 32'h107);
      cyc();
      check("t4_ho_hgrant", bus.hgrant, 64'h2);
      check("t4_ho_hmaster", bus.hmaster, 64'h1);
      check("t4_ho_haddr", bus.s_haddr, 64'h200);
      check("t4_ho_hwdata", bus.s_hwdata, 64'h107);

      // hreadyout low for 3 cycles at a handover edge
      drive(1, 1'b0, IDLE, 32'h200);
      set_wd(1, 32'h2AA);
      drive(0, 1'b1, NONSEQ, 32'h300);
      bus.hreadyout = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         check("t5_frz_hgrant", bus.hgrant, 64'h2);
         check("t5_frz_hmaster", bus.hmaster, 64'h1);
         check("t5_frz_hwdata", bus.s_hwdata, 64'h107);
      end
      bus.hreadyout = 1'b1;
      cyc();
      check("t5_rel_hgrant", bus.hgrant, 64'h1);
      check("t5_rel_hmaster", bus.hmaster, 64'h0);
      check("t5_rel_hwdata", bus.s_hwdata, 64'h2AA);

      // Beat cap of 4: no switch mid-SEQ, M1 wins at M0's next NONSEQ
      drive(1, 1'b1, NONSEQ, 32'h400);
      for (int k = 1; k < 8; k++) begin
         cyc();
         check("t6_hold_hgrant", bus.hgrant, 64'h1);
         drive(0, 1'b1, SEQ, 32'h300 + 32'(k));
      end
      cyc();
      check("t6_hold_last", bus.hgrant, 64'h1);
      drive(0, 1'b1, NONSEQ, 32'h308);
      cyc();
      check("t6_cap_hgrant", bus.hgrant, 64'h2);
      check("t6_cap_hmaster", bus.hmaster, 64'h1);
      check("t6_cap_haddr", bus.s_haddr, 64'h400);

      // Reset pulsed mid-burst
      cyc();
      check("t7_pre_hmaster", bus.hmaster, 64'h1);
      drive(1, 1'b1, SEQ, 32'h404);
      set_wd(1, 32'h5555);
      hreset = 1'b1;
      cyc();
      check("t7_rst_hgrant", bus.hgrant, 64'h1);
      check("t7_rst_hmaster", bus.hmaster, 64'h0);
      check("t7_rst_htrans", bus.s_htrans, IDLE);
      check("t7_rst_hwdata", bus.s_hwdata, 64'h107);
      hreset = 1'b0;
      drive(0, 1'b0, IDLE, 32'h0);
      drive(1, 1'b0, IDLE, 32'h0);
      cyc();
      check("t7_park_hgrant", bus.hgrant, 64'h1);
      check("t7_park_htrans", bus.s_htrans, IDLE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Round-robin, burst-aware AHB bus arbiter that shares one AHB slave port between `NUM_MASTERS` bus masters (instances of the team's AHB master). It sits between the masters and the slave. It registers the grant and the current owner, and multiplexes address/control and write data with the AHB one-cycle address/data phase offset. It broadcasts slave responses back to every master.

## Interface
Parameters:
- `NUM_MASTERS`, 2: number of requesters, 2..8.
- `DEFAULT_MASTER`, 0: index parked on when nobody requests.
- `MAX_BEATS`, 16: accepted transfers after which the owner is pre-empted at the next burst boundary.

Ports:
- `hclk`  in  1  bus clock; all logic is on the rising edge.
- `hreset`  in  1  reset, synchronous, active-high.
- `hbusreq`  in  NUM_MASTERS  per-master request.
- `m_haddr`  in  NUM_MASTERS*32  packed master addresses, master i at [32i+31:32i].
- `m_hwdata`  in  NUM_MASTERS*32  packed master write data.
- `m_hwrite`  in  NUM_MASTERS  master write flags.
- `m_htrans`  in  NUM_MASTERS*2  packed master transfer types.
- `m_hreadyin`  in  NUM_MASTERS  master hreadyin.
- `hreadyout`  in  1  slave ready.
- `hrdata`  in  32  slave read data.
- `hresp`  in  2  slave response.
- `hgrant`  out  NUM_MASTERS  one-hot grant, registered.
- `hmaster`  out  $clog2(NUM_MASTERS)  address-phase owner, registered.
- `s_haddr`, `s_hwdata`  out  32  to slave.
- `s_hwrite`, `s_hreadyin`  out  1  to slave.
- `s_htrans`  out  2  to slave.
- `m_hreadyout`  out  NUM_MASTERS  hreadyout replicated.
- `m_hrdata`  out  NUM_MASTERS*32  hrdata replicated.
- `m_hresp`  out  NUM_MASTERS*2  hresp replicated.

## Operation
- htrans encoding is the codebase's: IDLE=00, BUSY=01, SEQ=10, NONSEQ=11.
- FSM states:
  - PARK: no request is granted; `hgrant` is one-hot on DEFAULT_MASTER; `s_htrans` is forced to IDLE.
  - OWN: the granted master drives the bus.
- Arbitration point: any rising edge with `hreadyout`=1 where one of these holds:
  - state is PARK;
  - the owner drives IDLE;
  - the owner has dropped `hbusreq`;
  - the cap is hit: beat count ≥ MAX_BEATS and the owner drives NONSEQ or IDLE.
- Grant is never moved while the owner drives SEQ or BUSY. A single SEQ-then-IDLE transfer is therefore atomic.
- Selection: search starts at `last_owner+1` and wraps modulo NUM_MASTERS. The first master with `hbusreq` set wins and the FSM goes to OWN. If nobody requests, go to PARK. The owner may win again if it is the only requester.
- Beat counter: clears on every grant change. It increments on each `hreadyout`=1 edge where `s_htrans` is NONSEQ or SEQ, and saturates at MAX_BEATS.
- Address/control mux: `s_haddr`, `s_hwrite`, `s_htrans` and `s_hreadyin` are selected by `hmaster`.
- Data mux: `s_hwdata` is selected by `data_owner`. `data_owner` loads `hmaster` on every `hreadyout`=1 edge.
- `hreadyout`=0 freezes `hgrant`, `hmaster`, `data_owner`, the beat counter and the FSM.
- `hresp` is passed through only; it does not affect arbitration.

## Timing
- Reset values: `hgrant` one-hot on DEFAULT_MASTER; `hmaster`, `data_owner` and `last_owner` = DEFAULT_MASTER; state PARK; beat count 0; `s_htrans`=IDLE.
- Combinational outputs follow the reset-state muxes.
- Request-to-grant latency: 1 cycle minimum. A master requesting in cycle n, with `hreadyout`=1, sees `hgrant` and its address on `s_haddr` in cycle n+1.
- Handover: in the first cycle of the new owner's address phase, `s_hwdata` still carries the previous owner's final write data.
- Simultaneous requests from reset: the pointer starts at DEFAULT_MASTER, so the search order begins at DEFAULT_MASTER+1.
- Owner drops `hbusreq` mid-SEQ: the grant is held until SEQ/BUSY ends.
- `hreset` mid-burst: next edge returns every register to its reset value. The in-flight burst is abandoned.

## Structure
- Package `ahb_pkg`:
  - `htrans_t` enum with the encoding above;
  - `arb_state_t` {PARK, OWN};
  - constants for address and data widths.
- One sub-module, `rr_select`: combinational round-robin priority picker. Inputs are the request vector and the pointer; outputs are a one-hot winner and a valid flag.

## Test plan
- Reset, no requests -> `hgrant`=01, `hmaster`=0, `s_htrans`=IDLE every cycle.
- M1 requests alone, single write 0x2/data 0x2 -> `hgrant`=10 next cycle, `s_haddr`=0x2, then `s_hwdata`=0x2 one cycle later.
- M0 and M1 request together from reset -> M1 granted first. After M1 drives IDLE, M0 is granted.
- M0 8-beat burst 0x100..0x107, M1 requests at beat 3 -> no grant change until M0 IDLE. On the handover cycle, `s_haddr` comes from M1 and `s_hwdata`=0x107 from M0.
- `hreadyout` held low 3 cycles at a handover edge -> `hgrant` and `hmaster` are unchanged until `hreadyout` returns.
- MAX_BEATS=4, M0 issues back-to-back 8-beat bursts with M1 requesting -> no switch mid-SEQ. M1 is granted at M0's next NONSEQ.
- `hreset` pulsed mid-burst -> reset values on the next edge.
